pos_table_scanner: RTL and testbench

POS_TABLE_SCANNER -- requirements
Module: pos_table_scanner

---
 rtl/pos_table_scanner_pkg.sv | 17 +
 rtl/pos_function.sv | 13 +
 rtl/pos_table_scanner.sv | 139 +++++++++++++
 tb/tb_pos_table_scanner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pos_table_scanner_pkg.sv
// Shared types and constants for the PoS truth-table scanner.
package pos_table_scanner_pkg;

  localparam int unsigned ROWS  = 16;
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned CNT_W = ROW_W + 1;

  localparam logic [ROWS-1:0] POS_TABLE = 16'h1894;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/pos_function.sv
// Simplified product-of-sums; S=1 only for minterms 2, 4, 7, 11, 12 of {A,B,C,D}.
module pos_function (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic S
);

  assign S = (C | ~D) & (B | C) & (A | B | ~D) &
             (~B | ~C | D) & (~A | ~B | ~C) & (~A | B | D);

endmodule

// File: rtl/pos_table_scanner.sv
// Sweeps all 16 input rows through pos_function and compares against a latched golden table.
module pos_table_scanner
  import pos_table_scanner_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ROWS-1:0]   expected,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  row,
  output logic [ROWS-1:0]   table_out,
  output logic              match,
  output logic [CNT_W-1:0]  fail_count,
  output logic [ROW_W-1:0]  first_fail
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROW_W-1:0] abcd_q, abcd_d;
  logic [ROWS-1:0]  exp_q, exp_d;
  logic [ROWS-1:0]  table_q, table_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [ROW_W-1:0] first_q, first_d;
  logic             match_q, match_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s;
  logic             mism;

  pos_function u_func (
    .A (abcd_q[3]),
    .B (abcd_q[2]),
    .C (abcd_q[1]),
    .D (abcd_q[0]),
    .S (s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      abcd_q  <= '0;
      exp_q   <= '0;
      table_q <= '0;
      fail_q  <= '0;
      first_q <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      abcd_q  <= abcd_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Abort wins over every transition out of DRIVE/SAMPLE, including the capture.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    abcd_d  = abcd_q;
    exp_d   = exp_q;
    table_d = table_q;
    fail_d  = fail_q;
    first_d = first_q;
    match_d = match_q;
    mism    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          exp_d   = expected;
          table_d = '0;
          fail_d  = '0;
          first_d = '0;
          match_d = 1'b0;
          row_d   = '0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          abcd_d  = row_q;
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          table_d[row_q] = s;
          mism = (s != exp_q[row_q]);
          if (mism) begin
            fail_d = fail_q + CNT_W'(1);
            if (fail_q == '0) first_d = row_q;
          end
          if (row_q == LAST_ROW) begin
            match_d = (fail_d == '0);
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign row        = row_q;
  assign table_out  = table_q;
  assign match      = match_q;
  assign fail_count = fail_q;
  assign first_fail = first_q;

endmodule

// File: tb/tb_pos_table_scanner.sv
// Directed bench for pos_table_scanner: cycle-exact sweep timing, results, abort, reset and start filtering.
module tb_pos_table_scanner;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic        busy;
  logic        done;
  logic [3:0]  row;
  logic [15:0] table_out;
  logic        match;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail;

  int n_assert = 0;
  int n_fail   = 0;

  pos_table_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .expected   (expected),
    .busy       (busy),
    .done       (done),
    .row        (row),
    .table_out  (table_out),
    .match      (match),
    .fail_count (fail_count),
    .first_fail (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [15:0] t, input logic m,
                               input logic [4:0] f, input logic [3:0] ff);
    check({tag, "_table"}, 32'(table_out), 32'(t));
    check({tag, "_match"}, 32'(match), 32'(m));
    check({tag, "_fail"}, 32'(fail_count), 32'(f));
    check({tag, "_first"}, 32'(first_fail), 32'(ff));
  endtask

  // Start is sampled at edge 0; returns positioned at the falling edge inside cycle 1.
  task automatic launch(input logic [15:0] golden);
    @(negedge clk);
    expected = golden;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic full_sweep(input string tag, input logic [15:0] golden, input logic [15:0] t,
                            input logic m, input logic [4:0] f, input logic [3:0] ff);
    launch(golden);
    for (int c = 1; c <= 34; c++) begin
      check({tag, "_done"}, 32'(done), 32'(c == 33));
      check({tag, "_busy"}, 32'(busy), 32'(c <= 32));
      if (c <= 32) check({tag, "_row"}, 32'(row), 32'((c - 1) / 2));
      if (c == 33) check({tag, "_match_at_done"}, 32'(match), 32'(m));
      @(negedge clk);
    end
    check_results(tag, t, m, f, ff);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    expected = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check_results("rst", 16'h0000, 1'b0, 5'd0, 4'd0);
    rst = 1'b0;

    // Golden sweep and a wrong-golden sweep.
    full_sweep("golden", 16'h1894, 16'h1894, 1'b1, 5'd0, 4'd0);
    full_sweep("wrong", 16'h0000, 16'h1894, 1'b0, 5'd5, 4'd2);
    // Every row mismatches: fail_count reaches its 16 ceiling, first_fail is row 0.
    full_sweep("allbad", 16'he76b, 16'h1894, 1'b0, 5'd16, 4'd0);

    // Abort while row 4 is in SAMPLE (cycle 10).
    launch(16'h1894);
    for (int c = 1; c <= 10; c++) begin
      check("abort_busy_pre", 32'(busy), 32'd1);
      if (c == 10) begin
        check("abort_row", 32'(row), 32'd4);
        abort = 1'b1;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    for (int c = 11; c <= 40; c++) begin
      check("abort_busy_post", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    check("abort_table", 32'((table_out == 16'h0014) || (table_out == 16'h0004)), 32'd1);
    check("abort_fail", 32'(fail_count), 32'd0);
    check("abort_match", 32'(match), 32'd0);

    // Extra start pulses in cycles 5 and 20 must not restart or add a done.
    launch(16'h1894);
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5) || (c == 20);
      check("ignore_done", 32'(done), 32'(c == 33));
      @(negedge clk);
    end
    start = 1'b0;
    check_results("ignore", 16'h1894, 1'b1, 5'd0, 4'd0);

    // Reset in cycle 15 discards the sweep.
    launch(16'h0000);
    for (int c = 1; c <= 15; c++) begin
      if (c == 15) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_row", 32'(row), 32'd0);
    check_results("midrst", 16'h0000, 1'b0, 5'd0, 4'd0);
    for (int c = 17; c <= 40; c++) begin
      check("midrst_nodone", 32'(done), 32'd0);
      @(negedge clk);
    end
    full_sweep("postrst", 16'h1894, 16'h1894, 1'b1, 5'd0, 4'd0);

    // Start and abort together in IDLE: nothing starts, results hold.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("both_busy", 32'(busy), 32'd0);
      check("both_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    check_results("both", 16'h1894, 1'b1, 5'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
